store_narrow_rmw: RTL and testbench

- Store-side counterpart of the load/immediate sign-extension path: narrows a 32-bit register value to byte, halfword or word and writes it into word-organised data memory.
- Sub-word stores use read-modify-write: read word, merge lane, write word.
- Sits between the datapath store port and the data-memory word interface.
- Flags values whose upper bits are not a sign-extension of the stored field, i.e. the inverse check of sign extension.

---
 rtl/store_narrow_rmw_pkg.sv | 23 ++
 rtl/store_lane_merge.sv | 58 +++++
 rtl/store_narrow_rmw.sv | 183 ++++++++++++++++++
 tb/tb_store_narrow_rmw.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/store_narrow_rmw_pkg.sv
// Shared definitions for the narrowing store path.
// Holds the store size encodings, the controller state type and the width
// of the memory-wait timeout counter.
package store_narrow_rmw_pkg;

  // Store size encodings as they arrive on req_size.
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  // Wide enough for a timeout of up to 255 waiting cycles.
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    MERGE = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/store_lane_merge.sv
// Combinational lane merge for narrow stores.
// Ports:
//   old_word    in  32  word read back from memory
//   data        in  32  register value being stored
//   size        in  2   store size encoding
//   lane        in  2   byte address bits [1:0]
//   merged_word out 32  old_word with the selected lane replaced (data for word stores)
//   trunc_ovf   out 1   upper bits of data are not a sign extension of the stored field
//   misaligned  out 1   address not aligned to size, or illegal size
module store_lane_merge
  import store_narrow_rmw_pkg::*;
(
  input  logic [31:0] old_word,
  input  logic [31:0] data,
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  output logic [31:0] merged_word,
  output logic        trunc_ovf,
  output logic        misaligned
);

  // Lane replacement, truncation check and alignment check by store size.
  always_comb begin
    merged_word = old_word;
    trunc_ovf   = 1'b0;
    misaligned  = 1'b0;
    case (size)
      SZ_BYTE: begin
        // A byte is representable only if bits 31..7 are all copies of bit 7.
        trunc_ovf = ~((&data[31:7]) | ~(|data[31:7]));
        case (lane)
          2'd0:    merged_word[7:0]   = data[7:0];
          2'd1:    merged_word[15:8]  = data[7:0];
          2'd2:    merged_word[23:16] = data[7:0];
          2'd3:    merged_word[31:24] = data[7:0];
          default: merged_word        = old_word;
        endcase
      end
      SZ_HALF: begin
        trunc_ovf  = ~((&data[31:15]) | ~(|data[31:15]));
        misaligned = lane[0];
        if (lane[1]) begin
          merged_word[31:16] = data[15:0];
        end else begin
          merged_word[15:0] = data[15:0];
        end
      end
      SZ_WORD: begin
        merged_word = data;
        misaligned  = |lane;
      end
      default: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_rmw.sv
// Narrowing store controller: writes byte/half/word values into a
// word-organised memory, using read-modify-write for sub-word stores.
// Ports:
//   clk, rst              clock and synchronous active-high reset
//   req_valid/req_ready   store request handshake (ready only when idle)
//   req_addr/data/size    byte address, register value, size encoding
//   done                  one-cycle completion pulse
//   trunc_ovf, err        status, valid together with done
//   mem_addr              word address of the access
//   mem_rd/mem_rdata/mem_rvalid   level read request and its response
//   mem_wr/mem_wdata/mem_wack     level write request and its acknowledge
// Parameter TIMEOUT_CYCLES (1..255): waiting cycles before an access is dropped.
module store_narrow_rmw
  import store_narrow_rmw_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  input  logic [1:0]  req_size,
  output logic        done,
  output logic        trunc_ovf,
  output logic        err,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rvalid,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic        mem_wack
);

  // Count value seen on the last permitted waiting cycle.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [31:0]      addr_q, addr_d;
  logic [31:0]      data_q, data_d;
  logic [1:0]       size_q, size_d;
  logic [31:0]      rword_q, rword_d;
  logic [31:0]      wdata_q, wdata_d;
  logic             ovf_q, ovf_d;
  logic             err_q, err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [31:0] m_data_s;
  logic [1:0]  m_size_s;
  logic [1:0]  m_lane_s;
  logic [31:0] m_merged_s;
  logic        m_ovf_s;
  logic        m_mis_s;

  // In IDLE the merge unit classifies the incoming request; afterwards it
  // works on the captured request and the read-back word.
  always_comb begin
    if (state_q == IDLE) begin
      m_data_s = req_data;
      m_size_s = req_size;
      m_lane_s = req_addr[1:0];
    end else begin
      m_data_s = data_q;
      m_size_s = size_q;
      m_lane_s = addr_q[1:0];
    end
  end

  store_lane_merge u_merge (
    .old_word    (rword_q),
    .data        (m_data_s),
    .size        (m_size_s),
    .lane        (m_lane_s),
    .merged_word (m_merged_s),
    .trunc_ovf   (m_ovf_s),
    .misaligned  (m_mis_s)
  );

  // Next-state logic for the store sequence and the wait timeout.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    data_d  = data_q;
    size_d  = size_q;
    rword_d = rword_q;
    wdata_d = wdata_q;
    ovf_d   = ovf_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          data_d  = req_data;
          size_d  = req_size;
          wdata_d = req_data;  // already the final word for full-word stores
          ovf_d   = m_ovf_s;
          err_d   = m_mis_s;
          cnt_d   = '0;
          if (m_mis_s) begin
            state_d = DONE;
          end else if (req_size == SZ_WORD) begin
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end else begin
          state_d = IDLE;
        end
      end
      READ: begin
        if (mem_rvalid) begin
          rword_d = mem_rdata;
          state_d = MERGE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      MERGE: begin
        wdata_d = m_merged_s;
        cnt_d   = '0;
        state_d = WRITE;
      end
      WRITE: begin
        if (mem_wack) begin
          state_d = DONE;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= 32'h0000_0000;
      data_q  <= 32'h0000_0000;
      size_q  <= 2'b00;
      rword_q <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      ovf_q   <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      size_q  <= size_d;
      rword_q <= rword_d;
      wdata_q <= wdata_d;
      ovf_q   <= ovf_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs decode directly from registered state, so they are glitch-free.
  assign req_ready = (state_q == IDLE);
  assign mem_rd    = (state_q == READ);
  assign mem_wr    = (state_q == WRITE);
  assign done      = (state_q == DONE);
  assign trunc_ovf = (state_q == DONE) & ovf_q;
  assign err       = (state_q == DONE) & err_q;
  assign mem_addr  = {addr_q[31:2], 2'b00};
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_store_narrow_rmw.sv
// Randomized self-checking bench for store_narrow_rmw against a
// byte-array memory model and arithmetic range checks.
module tb_store_narrow_rmw;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [31:0] req_data;
  logic [1:0]  req_size;
  logic        done;
  logic        trunc_ovf;
  logic        err;
  logic [31:0] mem_addr;
  logic        mem_rd;
  logic [31:0] mem_rdata;
  logic        mem_rvalid;
  logic        mem_wr;
  logic [31:0] mem_wdata;
  logic        mem_wack;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [16];

  store_narrow_rmw #(.TIMEOUT_CYCLES(TO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_data   (req_data),
    .req_size   (req_size),
    .done       (done),
    .trunc_ovf  (trunc_ovf),
    .err        (err),
    .mem_addr   (mem_addr),
    .mem_rd     (mem_rd),
    .mem_rdata  (mem_rdata),
    .mem_rvalid (mem_rvalid),
    .mem_wr     (mem_wr),
    .mem_wdata  (mem_wdata),
    .mem_wack   (mem_wack)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Memory word after the store, built from individual bytes.
  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] data,
                                            input logic [1:0] size, input logic [31:0] addr);
    logic [7:0] b [4];
    for (int i = 0; i < 4; i++) b[i] = old[8*i +: 8];
    if (size == 2'b00) begin
      b[addr[1:0]] = data[7:0];
    end else if (size == 2'b01) begin
      b[{addr[1], 1'b0}] = data[7:0];
      b[{addr[1], 1'b1}] = data[15:8];
    end else begin
      return data;
    end
    return {b[3], b[2], b[1], b[0]};
  endfunction

  // Overflow means the signed value does not fit in the stored field.
  function automatic logic ref_ovf(input logic [31:0] data, input logic [1:0] size);
    longint v;
    v = longint'($signed(data));
    if (size == 2'b00) return (v < -128) || (v > 127);
    if (size == 2'b01) return (v < -32768) || (v > 32767);
    return 1'b0;
  endfunction

  task automatic do_store(input string name, input logic [31:0] addr, input logic [31:0] data,
                          input logic [1:0] size, input int rdly, input int wdly);
    int idx, exp_lat, done_at, rd_n, wr_n;
    logic mis, sub, rd_to, wr_to, exp_err, exp_ovf, exp_rd, exp_wr;
    logic saw_rd, saw_wr, wd_bad, addr_bad, both, got_ovf, got_err;
    logic [31:0] exp_w, first_wd;

    idx     = int'(addr[5:2]);
    mis     = (size == 2'b11) || (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
    sub     = (size == 2'b00) || (size == 2'b01);
    rd_to   = !mis && sub && (rdly >= int'(TO));
    wr_to   = !mis && !rd_to && (wdly >= int'(TO));
    exp_err = mis || rd_to || wr_to;
    exp_ovf = ref_ovf(data, size);
    exp_rd  = !mis && sub;
    exp_wr  = !mis && !rd_to;
    exp_w   = ref_merge(mem[idx], data, size, addr);
    if (mis)        exp_lat = 1;
    else if (rd_to) exp_lat = 1 + int'(TO);
    else if (sub)   exp_lat = 1 + (rdly + 1) + 1 + (wr_to ? int'(TO) : wdly + 1);
    else            exp_lat = 1 + (wr_to ? int'(TO) : wdly + 1);

    check({name, ".ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = addr;
    req_data  = data;
    req_size  = size;
    @(posedge clk);
    @(negedge clk);
    // Junk on the request bus while busy must not be picked up.
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_data  = $urandom;
    req_size  = 2'($urandom);

    rd_n = 0; wr_n = 0; done_at = -1;
    saw_rd = 1'b0; saw_wr = 1'b0; wd_bad = 1'b0; addr_bad = 1'b0; both = 1'b0;
    got_ovf = 1'b0; got_err = 1'b0; first_wd = 32'h0000_0000;
    for (int k = 1; k <= 40; k++) begin
      if (mem_rd && mem_wr) both = 1'b1;
      if ((mem_rd || mem_wr) && mem_addr !== {addr[31:2], 2'b00}) addr_bad = 1'b1;
      mem_rvalid = 1'b0;
      mem_wack   = 1'b0;
      if (mem_rd) begin
        saw_rd = 1'b1;
        if (rd_n == rdly) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mem[idx];
        end else begin
          mem_rdata = $urandom;
        end
        rd_n++;
      end else if (mem_wr) begin
        if (!saw_wr) first_wd = mem_wdata;
        else if (mem_wdata !== first_wd) wd_bad = 1'b1;
        saw_wr = 1'b1;
        if (wr_n == wdly) begin
          mem_wack = 1'b1;
          mem[idx] = mem_wdata;
        end
        wr_n++;
      end else begin
        // Stray responses outside READ/WRITE must be ignored.
        mem_rvalid = 1'($urandom);
        mem_wack   = 1'($urandom);
        mem_rdata  = $urandom;
      end
      if (done) begin
        done_at = k;
        got_ovf = trunc_ovf;
        got_err = err;
        break;
      end
      @(posedge clk);
      @(negedge clk);
    end

    check({name, ".lat"}, 32'(done_at), 32'(exp_lat));
    check({name, ".ovf"}, 32'(got_ovf), 32'(exp_ovf));
    check({name, ".err"}, 32'(got_err), 32'(exp_err));
    check({name, ".rd_seen"}, 32'(saw_rd), 32'(exp_rd));
    check({name, ".wr_seen"}, 32'(saw_wr), 32'(exp_wr));
    if (exp_wr) check({name, ".wdata"}, first_wd, exp_w);
    check({name, ".wd_stable"}, 32'(wd_bad), 32'd0);
    check({name, ".addr"}, 32'(addr_bad), 32'd0);
    check({name, ".rd_wr_excl"}, 32'(both), 32'd0);

    mem_rvalid = 1'b0;
    mem_wack   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({name, ".pulse"}, 32'(done), 32'd0);
  endtask

  task automatic reset_mid_write();
    check("rmw.ready", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_addr  = 32'h0000_0100;
    req_data  = 32'h0BAD_F00D;
    req_size  = 2'b10;
    mem_wack  = 1'b0;
    mem_rvalid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    check("rmw.wr_on", 32'(mem_wr), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rmw.wr_off", 32'(mem_wr), 32'd0);
    check("rmw.rd_off", 32'(mem_rd), 32'd0);
    check("rmw.ready_rst", 32'(req_ready), 32'd1);
    check("rmw.no_done", 32'(done), 32'd0);
    @(posedge clk);
    @(negedge clk);
    check("rmw.no_done2", 32'(done), 32'd0);
    check("rmw.idle", 32'(req_ready), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, d;
    logic [1:0]  s;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    rst = 1'b1; req_valid = 1'b0; req_addr = 32'h0; req_data = 32'h0; req_size = 2'b00;
    mem_rdata = 32'h0; mem_rvalid = 1'b0; mem_wack = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("rst.ready", 32'(req_ready), 32'd1);
    check("rst.done", 32'(done), 32'd0);
    check("rst.rd", 32'(mem_rd), 32'd0);
    check("rst.wr", 32'(mem_wr), 32'd0);
    check("rst.err_ovf", {30'd0, err, trunc_ovf}, 32'd0);
    check("rst.addr", mem_addr, 32'd0);
    check("rst.wdata", mem_wdata, 32'd0);

    do_store("w0", 32'h0000_0100, 32'hDEAD_BEEF, 2'b10, 0, 0);
    check("w0.mem", mem[0], 32'hDEAD_BEEF);
    mem[0] = 32'h1122_3344;
    do_store("b0", 32'h0000_0102, 32'h0000_007F, 2'b00, 0, 0);
    check("b0.mem", mem[0], 32'h117F_3344);
    do_store("b1", 32'h0000_0103, 32'h0000_0080, 2'b00, 0, 0);
    do_store("b2", 32'h0000_0101, 32'hFFFF_FF80, 2'b00, 1, 2);
    mem[0] = 32'hAAAA_BBBB;
    do_store("h0", 32'h0000_0202, 32'hFFFF_1234, 2'b01, 0, 0);
    check("h0.mem", mem[0], 32'h1234_BBBB);
    do_store("mis_h", 32'h0000_0201, 32'h0000_1234, 2'b01, 0, 0);
    do_store("ill", 32'h0000_0300, 32'h0000_0001, 2'b11, 0, 0);
    do_store("to_r", 32'h0000_0104, 32'h0000_0011, 2'b00, 10, 0);
    do_store("to_w", 32'h0000_0108, 32'h1234_5678, 2'b10, 0, 7);
    do_store("lim_r", 32'h0000_010C, 32'h0000_0022, 2'b00, int'(TO) - 1, int'(TO) - 1);
    reset_mid_write();

    for (int n = 0; n < 60; n++) begin
      a = $urandom;
      s = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'b01) a[0] = 1'b0;
        if (s == 2'b10) a[1:0] = 2'b00;
      end
      d = $urandom;
      if ($urandom_range(0, 2) == 0) d = 32'($signed(d[15:0]));
      else if ($urandom_range(0, 1) == 0) d = 32'($signed(d[7:0]));
      do_store("rnd", a, d, s, $urandom_range(0, 5), $urandom_range(0, 5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
